// File: rtl/wdog_pkg.sv
// Shared encodings for the watchdog controller: FSM states, register map,
// sequence keys and the LOAD reset value.
package wdog_pkg;

  typedef enum logic [2:0] {
    ST_DIS = 3'd0,
    ST_EN1 = 3'd1,
    ST_EN2 = 3'd2,
    ST_ENA = 3'd3,
    ST_DS1 = 3'd4,
    ST_DS2 = 3'd5,
    ST_KK1 = 3'd6,
    ST_KK2 = 3'd7
  } state_e;

  localparam logic [3:0]  ADDR_LOAD = 4'h0;
  localparam logic [3:0]  ADDR_EN   = 4'h1;
  localparam logic [3:0]  ADDR_ARM  = 4'hA;
  localparam logic [3:0]  ADDR_STAT = 4'hC;
  localparam logic [3:0]  ADDR_KICK = 4'hE;
  localparam logic [3:0]  ADDR_KEY  = 4'hF;

  localparam logic [31:0] KEY_ONE   = 32'h0000_0001;
  localparam logic [31:0] KEY_F     = 32'h0000_000F;
  localparam logic [31:0] KEY_AA    = 32'h0000_00AA;
  localparam logic [31:0] KEY_55    = 32'h0000_0055;
  localparam logic [31:0] LOAD_RST  = 32'hFFFF_FFFF;

  function automatic logic timer_on(input state_e s);
    return (s inside {ST_ENA, ST_DS1, ST_DS2, ST_KK1, ST_KK2});
  endfunction

endpackage

// File: rtl/wdog_ctrl.sv
// Watchdog controller: keyed enable/disable/kick sequences, protected LOAD
// register, sticky timeout IRQ and a saturating error counter.
//
// state | meaning
// DIS   | timer disabled, LOAD writable
// EN1   | enable: key 1 written, awaiting read of 0xA
// EN2   | enable: awaiting key F
// ENA   | timer running
// DS1   | disable: key F written, awaiting read of 0xA
// DS2   | disable: awaiting key 1
// KK1   | kick: 0xAA written, awaiting read of 0xE
// KK2   | kick: awaiting 0x55
module wdog_ctrl
  import wdog_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        WRITE,
  input  logic        READ,
  input  logic [3:0]  ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  input  logic        TIMEOUT,
  output logic        TIMER_EN,
  output logic        TIMER_DIS,
  output logic        KICK,
  output logic [31:0] LOAD_OUT,
  output logic        IRQ
);

  state_e      state_q, state_d;
  logic [31:0] load_q, rdata_q, rdata_d;
  logic [7:0]  err_q;
  logic        irq_q, kick_q, kick_d, ten_q;
  logic        wr, rd, coll, neutral, load_ok, irq_clr, err_inc, step_ok;

  assign wr      = WRITE & ~READ;
  assign rd      = READ & ~WRITE;
  assign coll    = WRITE & READ;
  assign neutral = (rd && (ADDR == ADDR_LOAD || ADDR == ADDR_STAT)) ||
                   (wr && ADDR == ADDR_STAT);
  assign load_ok = wr && ADDR == ADDR_LOAD && state_q == ST_DIS && WDATA != 32'h0;
  assign irq_clr = wr && ADDR == ADDR_STAT && WDATA[1];

  always_comb begin
    state_d = state_q;
    kick_d  = 1'b1;
    err_inc = 1'b0;
    step_ok = 1'b0;
    if (coll || ((wr || rd) && !neutral && !load_ok)) begin
      if (!coll) begin
        unique case (state_q)
          ST_DIS: if (wr && ADDR == ADDR_EN && WDATA == KEY_ONE) begin
            state_d = ST_EN1; step_ok = 1'b1;
          end
          ST_EN1: if (rd && ADDR == ADDR_ARM) begin
            state_d = ST_EN2; step_ok = 1'b1;
          end
          ST_EN2: if (wr && ADDR == ADDR_KEY && WDATA == KEY_F) begin
            state_d = ST_ENA; step_ok = 1'b1;
          end
          ST_ENA: begin
            if (wr && ADDR == ADDR_KEY && WDATA == KEY_F) begin
              state_d = ST_DS1; step_ok = 1'b1;
            end else if (wr && ADDR == ADDR_KICK && WDATA == KEY_AA) begin
              state_d = ST_KK1; step_ok = 1'b1;
            end
          end
          ST_DS1: if (rd && ADDR == ADDR_ARM) begin
            state_d = ST_DS2; step_ok = 1'b1;
          end
          ST_DS2: if (wr && ADDR == ADDR_EN && WDATA == KEY_ONE) begin
            state_d = ST_DIS; step_ok = 1'b1;
          end
          ST_KK1: if (rd && ADDR == ADDR_KICK) begin
            state_d = ST_KK2; step_ok = 1'b1;
          end
          ST_KK2: if (wr && ADDR == ADDR_KICK && WDATA == KEY_55) begin
            state_d = ST_ENA; step_ok = 1'b1; kick_d = 1'b0;
          end
          default: ;
        endcase
      end
      // Any wrong step falls back to the resting state of its own side.
      if (!step_ok) begin
        err_inc = 1'b1;
        state_d = (state_q inside {ST_DIS, ST_EN1, ST_EN2}) ? ST_DIS : ST_ENA;
      end
    end
  end

  always_comb begin
    rdata_d = 32'h0;
    if (rd) begin
      if (ADDR == ADDR_LOAD)      rdata_d = load_q;
      else if (ADDR == ADDR_STAT) rdata_d = {16'h0, err_q, 1'b0, state_q, 2'b0, irq_q, ten_q};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_DIS;
      ten_q   <= 1'b0;
      kick_q  <= 1'b1;
      load_q  <= LOAD_RST;
      irq_q   <= 1'b0;
      err_q   <= 8'h00;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ten_q   <= timer_on(state_d);
      kick_q  <= kick_d;
      if (load_ok) load_q <= WDATA;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (TIMEOUT && ten_q) irq_q <= 1'b1;
      else if (irq_clr)     irq_q <= 1'b0;
      if (rd || coll) rdata_q <= rdata_d;
    end
  end

  assign RDATA     = rdata_q;
  assign TIMER_EN  = ten_q;
  assign TIMER_DIS = ~ten_q;
  assign KICK      = kick_q;
  assign LOAD_OUT  = load_q;
  assign IRQ       = irq_q;

endmodule

// File: tb/tb_wdog_ctrl.sv
// Bench for wdog_ctrl: directed scenarios plus random traffic against a
// table-driven reference model of the access sequences.
module tb_wdog_ctrl;
  import wdog_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0, WRITE = 1'b0, READ = 1'b0, TIMEOUT = 1'b0;
  logic [3:0]  ADDR = 4'h0;
  logic [31:0] WDATA = 32'h0;
  logic [31:0] RDATA, LOAD_OUT;
  logic        TIMER_EN, TIMER_DIS, KICK, IRQ;

  int n_tests = 0;
  int n_fail  = 0;

  wdog_ctrl dut (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .READ(READ), .ADDR(ADDR),
    .WDATA(WDATA), .RDATA(RDATA), .TIMEOUT(TIMEOUT), .TIMER_EN(TIMER_EN),
    .TIMER_DIS(TIMER_DIS), .KICK(KICK), .LOAD_OUT(LOAD_OUT), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    state_e     from;
    bit         is_w;
    logic [3:0] a;
    logic [31:0] d;
    state_e     to;
  } step_t;

  step_t seq_tbl[9];

  state_e      m_state;
  logic [31:0] m_load, m_rdata;
  logic [7:0]  m_err;
  bit          m_irq, m_kick, m_ten;

  function automatic bit running(input state_e s);
    return s == ST_ENA || s == ST_DS1 || s == ST_DS2 || s == ST_KK1 || s == ST_KK2;
  endfunction

  function automatic logic [31:0] status_word();
    return {16'h0, m_err, 1'b0, 3'(m_state), 2'b0, m_irq, m_ten};
  endfunction

  // Drive one access for a cycle and advance the reference model to match.
  task automatic cyc(input bit rst, input bit w, input bit r, input logic [3:0] a,
                     input logic [31:0] d, input bit to);
    state_e      n_state;
    logic [31:0] n_load, n_rdata;
    logic [7:0]  n_err;
    bit          n_irq, n_kick, coll, neutral, load_ok, found;
    RST = rst; WRITE = w; READ = r; ADDR = a; WDATA = d; TIMEOUT = to;
    coll    = w && r;
    neutral = !coll && ((r && (a == 4'h0 || a == 4'hC)) || (w && a == 4'hC));
    load_ok = !coll && w && a == 4'h0 && m_state == ST_DIS && d != 0;
    n_state = m_state; n_load = m_load; n_rdata = m_rdata; n_err = m_err;
    n_irq = m_irq; n_kick = 1'b1;
    if ((w || r) && !neutral && !load_ok) begin
      found = 1'b0;
      if (!coll)
        foreach (seq_tbl[i])
          if (!found && seq_tbl[i].from == m_state && seq_tbl[i].is_w == w &&
              seq_tbl[i].a == a && (!w || seq_tbl[i].d == d)) begin
            found = 1'b1;
            n_state = seq_tbl[i].to;
            if (m_state == ST_KK2) n_kick = 1'b0;
          end
      if (!found) begin
        n_state = (m_state == ST_DIS || m_state == ST_EN1 || m_state == ST_EN2) ? ST_DIS : ST_ENA;
        n_err = (m_err == 8'd255) ? 8'd255 : m_err + 8'd1;
      end
    end
    if (load_ok) n_load = d;
    if (!coll && w && a == 4'hC && d[1]) n_irq = 1'b0;
    if (to && m_ten) n_irq = 1'b1;
    if (coll) n_rdata = 32'h0;
    else if (r) n_rdata = (a == 4'h0) ? m_load : (a == 4'hC) ? status_word() : 32'h0;
    @(posedge CLK); #1;
    if (rst) begin
      m_state = ST_DIS; m_load = 32'hFFFF_FFFF; m_rdata = 32'h0; m_err = 8'h0;
      m_irq = 1'b0; m_kick = 1'b1; m_ten = 1'b0;
    end else begin
      m_state = n_state; m_load = n_load; m_rdata = n_rdata; m_err = n_err;
      m_irq = n_irq; m_kick = n_kick; m_ten = running(n_state);
    end
  endtask

  task automatic idle(); cyc(0, 0, 0, 4'h0, 32'h0, 0); endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d); cyc(0, 1, 0, a, d, 0); endtask
  task automatic rd(input logic [3:0] a); cyc(0, 0, 1, a, 32'h0, 0); endtask

  task automatic test_reset();
    cyc(1, 0, 0, 4'h0, 32'h0, 0);
    n_tests++;
    if ({TIMER_EN, TIMER_DIS, KICK, IRQ} !== 4'b0110) begin
      n_fail++; $display("FAIL reset_flags: got en/dis/kick/irq=%b%b%b%b want 0110", TIMER_EN, TIMER_DIS, KICK, IRQ);
    end
    n_tests++;
    if (LOAD_OUT !== 32'hFFFF_FFFF || RDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got load=%h rdata=%h want ffffffff/0", LOAD_OUT, RDATA);
    end
  endtask

  task automatic test_enable();
    wr(4'h0, 32'h10); wr(4'h1, 32'h1); rd(4'hA);
    n_tests++;
    if (TIMER_EN !== 1'b0) begin
      n_fail++; $display("FAIL enable_early: got timer_en=%b want 0", TIMER_EN);
    end
    wr(4'hF, 32'hF);
    n_tests++;
    if (LOAD_OUT !== 32'h10 || TIMER_EN !== 1'b1 || TIMER_DIS !== 1'b0) begin
      n_fail++; $display("FAIL enable_done: got load=%h en=%b dis=%b want 10/1/0", LOAD_OUT, TIMER_EN, TIMER_DIS);
    end
  endtask

  task automatic test_kick();
    wr(4'hE, 32'hAA); rd(4'hE);
    n_tests++;
    if (KICK !== 1'b1) begin
      n_fail++; $display("FAIL kick_early: got kick=%b want 1", KICK);
    end
    wr(4'hE, 32'h55);
    n_tests++;
    if (KICK !== 1'b0) begin
      n_fail++; $display("FAIL kick_pulse: got kick=%b want 0", KICK);
    end
    rd(4'hC);
    n_tests++;
    if (KICK !== 1'b1 || RDATA !== 32'h0000_0031) begin
      n_fail++; $display("FAIL kick_after: got kick=%b status=%h want 1/00000031", KICK, RDATA);
    end
  endtask

  task automatic test_kick_abort();
    wr(4'hE, 32'hAA); wr(4'hE, 32'h55);
    n_tests++;
    if (KICK !== 1'b1) begin
      n_fail++; $display("FAIL kick_abort_pulse: got kick=%b want 1", KICK);
    end
    rd(4'hC);
    n_tests++;
    if (RDATA !== 32'h0000_0131 || KICK !== 1'b1) begin
      n_fail++; $display("FAIL kick_abort_status: got status=%h kick=%b want 00000131/1", RDATA, KICK);
    end
  endtask

  task automatic test_load_protect();
    wr(4'h0, 32'h20);
    rd(4'hC);
    n_tests++;
    if (LOAD_OUT !== 32'h10 || RDATA[15:8] !== 8'd2) begin
      n_fail++; $display("FAIL load_in_ena: got load=%h err=%0d want 10/2", LOAD_OUT, RDATA[15:8]);
    end
    wr(4'hF, 32'hF); rd(4'hA); wr(4'h1, 32'h1);
    wr(4'h0, 32'h0);
    rd(4'hC);
    n_tests++;
    if (LOAD_OUT !== 32'h10 || RDATA !== 32'h0000_0301 - 32'h1 || TIMER_EN !== 1'b0) begin
      n_fail++; $display("FAIL load_zero: got load=%h status=%h en=%b want 10/00000300/0", LOAD_OUT, RDATA, TIMER_EN);
    end
  endtask

  task automatic test_timeout();
    cyc(0, 0, 0, 4'h0, 32'h0, 1);
    n_tests++;
    if (IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq_dis: got irq=%b want 0", IRQ);
    end
    wr(4'h1, 32'h1); rd(4'hA); wr(4'hF, 32'hF);
    cyc(0, 0, 0, 4'h0, 32'h0, 1);
    n_tests++;
    if (IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq_ena: got irq=%b want 1", IRQ);
    end
    cyc(0, 1, 0, 4'hC, 32'h2, 1);
    n_tests++;
    if (IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq_set_wins: got irq=%b want 1", IRQ);
    end
    wr(4'hC, 32'h2);
    n_tests++;
    if (IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got irq=%b want 0", IRQ);
    end
  endtask

  task automatic test_random();
    logic [3:0]  apool[7]  = '{4'h0, 4'h1, 4'hA, 4'hC, 4'hE, 4'hF, 4'h5};
    logic [31:0] dpool[6]  = '{32'h1, 32'hF, 32'hAA, 32'h55, 32'h2, 32'h0};
    cyc(1, 0, 0, 4'h0, 32'h0, 0);
    for (int n = 0; n < 600; n++) begin
      bit rst, w, r, to;
      logic [3:0] a;
      logic [31:0] d;
      int pick;
      rst = ($urandom_range(0, 99) == 0);
      to  = ($urandom_range(0, 7) == 0);
      a   = apool[$urandom_range(0, 6)];
      d   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : dpool[$urandom_range(0, 5)];
      w   = $urandom_range(0, 1);
      r   = ($urandom_range(0, 5) == 0) ? 1'b1 : !w;
      if ($urandom_range(0, 1) == 1) begin
        pick = -1;
        foreach (seq_tbl[i]) if (seq_tbl[i].from == m_state && (pick < 0 || $urandom_range(0, 1) == 1)) pick = i;
        if (pick >= 0) begin
          w = seq_tbl[pick].is_w; r = !w; a = seq_tbl[pick].a; d = seq_tbl[pick].d;
        end
      end
      cyc(rst, w, r, a, d, to);
      n_tests++;
      if ({RDATA, LOAD_OUT, TIMER_EN, TIMER_DIS, KICK, IRQ} !==
          {m_rdata, m_load, m_ten, !m_ten, m_kick, m_irq}) begin
        n_fail++;
        $display("FAIL rand_%0d: got rdata=%h load=%h en=%b dis=%b kick=%b irq=%b want rdata=%h load=%h en=%b kick=%b irq=%b",
                 n, RDATA, LOAD_OUT, TIMER_EN, TIMER_DIS, KICK, IRQ, m_rdata, m_load, m_ten, m_kick, m_irq);
      end
    end
  endtask

  task automatic test_saturation();
    cyc(1, 0, 0, 4'h0, 32'h0, 0);
    rd(4'h0);
    repeat (300) cyc(0, 1, 1, 4'h0, 32'h7, 0);
    n_tests++;
    if (RDATA !== 32'h0 || LOAD_OUT !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL collision_rdata: got rdata=%h load=%h want 0/ffffffff", RDATA, LOAD_OUT);
    end
    rd(4'hC);
    n_tests++;
    if (RDATA !== 32'h0000_FF00) begin
      n_fail++; $display("FAIL err_saturate: got status=%h want 0000ff00", RDATA);
    end
    wr(4'h1, 32'h1); rd(4'hA); rd(4'hC);
    n_tests++;
    if (RDATA !== 32'h0000_FF20) begin
      n_fail++; $display("FAIL in_en2: got status=%h want 0000ff20", RDATA);
    end
    cyc(1, 1, 0, 4'h0, 32'h5, 1);
    n_tests++;
    if ({TIMER_EN, TIMER_DIS, KICK, IRQ} !== 4'b0110 || LOAD_OUT !== 32'hFFFF_FFFF || RDATA !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_seq: got en/dis/kick/irq=%b%b%b%b load=%h rdata=%h want 0110/ffffffff/0",
                         TIMER_EN, TIMER_DIS, KICK, IRQ, LOAD_OUT, RDATA);
    end
    rd(4'hC);
    n_tests++;
    if (RDATA !== 32'h0 || RDATA !== m_rdata) begin
      n_fail++; $display("FAIL rst_status: got status=%h want 00000000", RDATA);
    end
  endtask

  initial begin
    seq_tbl[0] = '{ST_DIS, 1'b1, 4'h1, 32'h1,  ST_EN1};
    seq_tbl[1] = '{ST_EN1, 1'b0, 4'hA, 32'h0,  ST_EN2};
    seq_tbl[2] = '{ST_EN2, 1'b1, 4'hF, 32'hF,  ST_ENA};
    seq_tbl[3] = '{ST_ENA, 1'b1, 4'hF, 32'hF,  ST_DS1};
    seq_tbl[4] = '{ST_DS1, 1'b0, 4'hA, 32'h0,  ST_DS2};
    seq_tbl[5] = '{ST_DS2, 1'b1, 4'h1, 32'h1,  ST_DIS};
    seq_tbl[6] = '{ST_ENA, 1'b1, 4'hE, 32'hAA, ST_KK1};
    seq_tbl[7] = '{ST_KK1, 1'b0, 4'hE, 32'h0,  ST_KK2};
    seq_tbl[8] = '{ST_KK2, 1'b1, 4'hE, 32'h55, ST_ENA};
    m_state = ST_DIS; m_load = 32'hFFFF_FFFF; m_rdata = 32'h0; m_err = 8'h0;
    m_irq = 1'b0; m_kick = 1'b1; m_ten = 1'b0;
    test_reset();
    test_enable();
    test_kick();
    test_kick_abort();
    test_load_protect();
    test_timeout();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
